ahb_dual_master_arbiter: RTL and testbench
==========================================

# ahb_dual_master_arbiter

Two-master AHB-Lite arbiter that shares the single zero-wait-state memory/console slave port between the Cortex-M0 (M0) and a second bus master (M1), e.g. a program loader or traffic generator. It sits between the masters and the memory interface and issues one address phase per cycle to the slave. Losing requests are captured and the losing master is stalled through its own HREADY. A requester is never dropped.

## Interface
Parameters:
- AW, 32, address width
- DW, 32, data width

Ports:
- sim_clock  in  1  clock; all state on rising edge
- power_on_reset_n  in  1  asynchronous, active-low reset
- m0_haddr, m1_haddr  in  AW  master address
- m0_htrans, m1_htrans  in  2  master transfer type; bit 1 set = request
- m0_hwrite, m1_hwrite  in  1  master write
- m0_hsize, m1_hsize  in  3  master size
- m0_hwdata, m1_hwdata  in  DW  master write data (data phase)
- m0_hready, m1_hready  out  1  per-master ready
- m0_hresp, m1_hresp  out  1  per-master error response
- m_hrdata  out  DW  read data, broadcast to both masters
- s_haddr  out  AW  slave address
- s_htrans  out  2  slave transfer type; only IDLE (00) or NONSEQ (10)
- s_hwrite  out  1  slave write
- s_hsize  out  3  slave size
- s_hwdata  out  DW  slave write data
- s_hrdata  in  DW  slave read data
- s_hready  in  1  slave ready
- s_hresp  in  1  slave error

## Operation
- Per-master state:
  - pend_m: 1-entry holding register with addr, write and size.
  - dvalid: data phase in flight.
  - owner: which master owns that data phase.
  - last_grant: which master was granted most recently.
- live_m = mX_htrans[1] & mX_hready & !pend_m. A live request is accepted by the master on this edge.
- req_m = pend_m | live_m. The request source is the pend entry if one is held, otherwise the live bus.
- Arbitration happens only when s_hready = 1:
  - One requester: it is granted.
  - Two requesters: the master other than last_grant is granted (round-robin).
  - The granted source drives s_haddr, s_hwrite and s_hsize. s_htrans = NONSEQ; SEQ is always converted to NONSEQ.
  - No requester, or s_hready = 0: s_htrans = IDLE and s_haddr, s_hwrite, s_hsize = 0.
- On the granting edge: dvalid <= 1, owner <= granted, last_grant <= granted, pend of the granted master cleared. With no grant while s_hready = 1: dvalid <= 0.
- Capture: if live_m and master m is not granted this cycle (lost arbitration, or s_hready = 0), load pend_m from the live bus.
- mX_hready:
  - 0 while pend_m = 1.
  - Otherwise s_hready if dvalid & owner = m.
  - Otherwise 1.
- s_hwdata = hwdata of owner. mX_hresp = s_hresp if owner = m & dvalid, else 0.
- An error response does not cancel a pending entry; the pending transfer is still issued.

## Timing
- Reset values:
  - Registers: pend_m = 0, dvalid = 0, last_grant = M1 so M0 wins the first tie, owner = M0.
  - Outputs: s_htrans = IDLE, s_haddr/s_hwrite/s_hsize = 0, mX_hready = 1, mX_hresp = 0.
- Address path is combinational: a sole live requester reaches the slave in the same cycle with 0 added latency.
- A captured request is issued no earlier than the next cycle with s_hready = 1. Its master sees hready = 0 from the capture edge until that transfer's data phase completes. Stall added is 1 cycle per lost tie with a zero-wait slave.
- Every issued address phase is followed by exactly one data phase. Write data is taken from the owner in the cycle after issue, and held while s_hready = 0.
- Slave wait states (s_hready = 0):
  - No new grants are made.
  - The data-phase owner is stalled.
  - A non-owner live request is captured.
- A master with pend_m set has its live bus ignored until pend_m clears.
- Reset assertion mid-transfer clears pending entries and the data phase asynchronously. Masters are reset by the same signal.

## Test plan
- M0 only, NONSEQ read of 0x0000_0100, then write 0x1234_5678 to 0x0000_0104 -> s_haddr matches in the same cycle, m0_hready stays 1, s_hwdata = 0x1234_5678 in the next cycle.
- M0 and M1 both request in the first cycle after reset (0x100, 0x200) -> M0 is issued first, m1_hready = 0 for 1 cycle, 0x200 is issued next cycle; a subsequent simultaneous tie is granted to the other master.
- M1 write 0xCAFE_F00D captured behind M0 -> issued one cycle later with s_hwrite = 1; s_hwdata = 0xCAFE_F00D in the data phase; m1_hready returns to 1 at that data-phase completion.
- s_hready held at 0 for 3 cycles during an M0 data phase while M1 requests -> s_htrans = IDLE, M1 captured, both hready = 0; M1 is issued on the first cycle s_hready = 1.
- M0 drives SEQ at 0x108 -> s_htrans = NONSEQ; s_hresp = 1 for an M1 data phase -> only m1_hresp asserts.
- Assert power_on_reset_n low while pend_m1 = 1 -> after release, s_htrans = IDLE, both hready = 1, and no stale transfer is issued.

Source files
------------

// File: rtl/ahb_dual_master_arbiter.sv
// Two-master AHB-Lite arbiter in front of one zero-wait slave port.
// Losing or stalled requests are held in a 1-entry pend register per master.
module ahb_dual_master_arbiter #(
    parameter int AW = 32,
    parameter int DW = 32
) (
    input  logic          sim_clock,
    input  logic          power_on_reset_n,
    input  logic [AW-1:0] m0_haddr,
    input  logic [1:0]    m0_htrans,
    input  logic          m0_hwrite,
    input  logic [2:0]    m0_hsize,
    input  logic [DW-1:0] m0_hwdata,
    output logic          m0_hready,
    output logic          m0_hresp,
    input  logic [AW-1:0] m1_haddr,
    input  logic [1:0]    m1_htrans,
    input  logic          m1_hwrite,
    input  logic [2:0]    m1_hsize,
    input  logic [DW-1:0] m1_hwdata,
    output logic          m1_hready,
    output logic          m1_hresp,
    output logic [DW-1:0] m_hrdata,
    output logic [AW-1:0] s_haddr,
    output logic [1:0]    s_htrans,
    output logic          s_hwrite,
    output logic [2:0]    s_hsize,
    output logic [DW-1:0] s_hwdata,
    input  logic [DW-1:0] s_hrdata,
    input  logic          s_hready,
    input  logic          s_hresp
);

    logic [1:0]    pend_q, pend_d;
    logic [AW-1:0] pend_addr_q [2];
    logic [AW-1:0] pend_addr_d [2];
    logic [1:0]    pend_write_q, pend_write_d;
    logic [2:0]    pend_size_q [2];
    logic [2:0]    pend_size_d [2];
    logic          dvalid_q, dvalid_d;
    logic          owner_q, owner_d;
    logic          last_grant_q, last_grant_d;

    logic [AW-1:0] bus_addr_s [2];
    logic [2:0]    bus_size_s [2];
    logic [1:0]    bus_req_s, bus_write_s;
    logic [1:0]    hready_s, live_s, req_s;
    logic          gnt_valid_s, gnt_sel_s;
    logic          unused_s;

    // Only HTRANS[1] matters: SEQ is treated exactly like NONSEQ.
    assign unused_s = ^{m0_htrans[0], m1_htrans[0]};

    // Gather both master buses into indexable form
    always_comb begin
        bus_addr_s[0] = m0_haddr;
        bus_addr_s[1] = m1_haddr;
        bus_size_s[0] = m0_hsize;
        bus_size_s[1] = m1_hsize;
        bus_req_s     = {m1_htrans[1], m0_htrans[1]};
        bus_write_s   = {m1_hwrite, m0_hwrite};
    end

    // Per-master ready, live/pending request and round-robin grant
    always_comb begin
        hready_s = 2'b00;
        for (int m = 0; m < 2; m++) begin
            if (pend_q[m]) begin
                hready_s[m] = 1'b0;
            end else if (dvalid_q && (owner_q == 1'(m))) begin
                hready_s[m] = s_hready;
            end else begin
                hready_s[m] = 1'b1;
            end
        end
        live_s      = bus_req_s & hready_s & ~pend_q;
        req_s       = pend_q | live_s;
        gnt_valid_s = s_hready & (|req_s);
        if (&req_s) begin
            gnt_sel_s = ~last_grant_q;
        end else begin
            gnt_sel_s = req_s[1];
        end
    end

    // Slave address phase, sourced from pend entry when one is held
    always_comb begin
        s_htrans = 2'b00;
        s_haddr  = {AW{1'b0}};
        s_hwrite = 1'b0;
        s_hsize  = 3'd0;
        if (gnt_valid_s) begin
            s_htrans = 2'b10;
            if (pend_q[gnt_sel_s]) begin
                s_haddr  = pend_addr_q[gnt_sel_s];
                s_hwrite = pend_write_q[gnt_sel_s];
                s_hsize  = pend_size_q[gnt_sel_s];
            end else begin
                s_haddr  = bus_addr_s[gnt_sel_s];
                s_hwrite = bus_write_s[gnt_sel_s];
                s_hsize  = bus_size_s[gnt_sel_s];
            end
        end else begin
            s_htrans = 2'b00;
        end
    end

    // Next-state: pend capture/clear and data-phase tracking
    always_comb begin
        pend_d       = pend_q;
        pend_addr_d  = pend_addr_q;
        pend_write_d = pend_write_q;
        pend_size_d  = pend_size_q;
        dvalid_d     = dvalid_q;
        owner_d      = owner_q;
        last_grant_d = last_grant_q;
        for (int m = 0; m < 2; m++) begin
            if (gnt_valid_s && (gnt_sel_s == 1'(m))) begin
                pend_d[m] = 1'b0;
            end else if (live_s[m]) begin
                pend_d[m]       = 1'b1;
                pend_addr_d[m]  = bus_addr_s[m];
                pend_write_d[m] = bus_write_s[m];
                pend_size_d[m]  = bus_size_s[m];
            end else begin
                pend_d[m] = pend_q[m];
            end
        end
        if (gnt_valid_s) begin
            dvalid_d     = 1'b1;
            owner_d      = gnt_sel_s;
            last_grant_d = gnt_sel_s;
        end else if (s_hready) begin
            dvalid_d = 1'b0;
        end else begin
            dvalid_d = dvalid_q;
        end
    end

    // State registers; last_grant resets to M1 so M0 wins the first tie
    always_ff @(posedge sim_clock or negedge power_on_reset_n) begin
        if (!power_on_reset_n) begin
            pend_q       <= 2'b00;
            pend_write_q <= 2'b00;
            for (int m = 0; m < 2; m++) begin
                pend_addr_q[m] <= {AW{1'b0}};
                pend_size_q[m] <= 3'd0;
            end
            dvalid_q     <= 1'b0;
            owner_q      <= 1'b0;
            last_grant_q <= 1'b1;
        end else begin
            pend_q       <= pend_d;
            pend_addr_q  <= pend_addr_d;
            pend_write_q <= pend_write_d;
            pend_size_q  <= pend_size_d;
            dvalid_q     <= dvalid_d;
            owner_q      <= owner_d;
            last_grant_q <= last_grant_d;
        end
    end

    assign m0_hready = hready_s[0];
    assign m1_hready = hready_s[1];
    assign m0_hresp  = s_hresp & dvalid_q & ~owner_q;
    assign m1_hresp  = s_hresp & dvalid_q & owner_q;
    assign s_hwdata  = owner_q ? m1_hwdata : m0_hwdata;
    assign m_hrdata  = s_hrdata;

endmodule

// File: tb/tb_ahb_dual_master_arbiter.sv
// Directed bench for ahb_dual_master_arbiter: ties, capture, wait states, errors, reset.
module tb_ahb_dual_master_arbiter;

    logic        sim_clock = 1'b0;
    logic        power_on_reset_n;
    logic [31:0] m0_haddr, m1_haddr, m0_hwdata, m1_hwdata;
    logic [1:0]  m0_htrans, m1_htrans;
    logic        m0_hwrite, m1_hwrite;
    logic [2:0]  m0_hsize, m1_hsize;
    logic        m0_hready, m1_hready, m0_hresp, m1_hresp;
    logic [31:0] m_hrdata, s_haddr, s_hwdata, s_hrdata;
    logic [1:0]  s_htrans;
    logic        s_hwrite, s_hready, s_hresp;
    logic [2:0]  s_hsize;

    int checks = 0;
    int failures = 0;

    ahb_dual_master_arbiter #(.AW(32), .DW(32)) dut (
        .sim_clock(sim_clock), .power_on_reset_n(power_on_reset_n),
        .m0_haddr(m0_haddr), .m0_htrans(m0_htrans), .m0_hwrite(m0_hwrite),
        .m0_hsize(m0_hsize), .m0_hwdata(m0_hwdata), .m0_hready(m0_hready), .m0_hresp(m0_hresp),
        .m1_haddr(m1_haddr), .m1_htrans(m1_htrans), .m1_hwrite(m1_hwrite),
        .m1_hsize(m1_hsize), .m1_hwdata(m1_hwdata), .m1_hready(m1_hready), .m1_hresp(m1_hresp),
        .m_hrdata(m_hrdata), .s_haddr(s_haddr), .s_htrans(s_htrans), .s_hwrite(s_hwrite),
        .s_hsize(s_hsize), .s_hwdata(s_hwdata), .s_hrdata(s_hrdata),
        .s_hready(s_hready), .s_hresp(s_hresp)
    );

    always #5 sim_clock = ~sim_clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge sim_clock);
        #1;
    endtask

    task automatic drv0(input logic [1:0] t, input logic [31:0] a, input logic w);
        m0_htrans = t; m0_haddr = a; m0_hwrite = w;
    endtask

    task automatic drv1(input logic [1:0] t, input logic [31:0] a, input logic w);
        m1_htrans = t; m1_haddr = a; m1_hwrite = w;
    endtask

    initial begin
        power_on_reset_n = 1'b0;
        drv0(2'b00, 32'h0, 1'b0); drv1(2'b00, 32'h0, 1'b0);
        m0_hsize = 3'd2; m1_hsize = 3'd2;
        m0_hwdata = 32'h0; m1_hwdata = 32'h0;
        s_hrdata = 32'h0; s_hready = 1'b1; s_hresp = 1'b0;
        tick(); tick();
        chk("rst_htrans", {30'd0, s_htrans}, 32'h0);
        chk("rst_haddr", s_haddr, 32'h0);
        chk("rst_m0_hready", {31'd0, m0_hready}, 32'h1);
        chk("rst_m1_hready", {31'd0, m1_hready}, 32'h1);
        chk("rst_hresp", {30'd0, m1_hresp, m0_hresp}, 32'h0);
        power_on_reset_n = 1'b1;
        tick();

        // First tie after reset: M0 first, M1 captured then issued
        drv0(2'b10, 32'h100, 1'b0); drv1(2'b10, 32'h200, 1'b0); #1;
        chk("tie1_addr", s_haddr, 32'h100);
        chk("tie1_htrans", {30'd0, s_htrans}, 32'h2);
        tick();
        drv0(2'b00, 32'h0, 1'b0); drv1(2'b00, 32'h0, 1'b0); #1;
        chk("tie1_m1_stall", {31'd0, m1_hready}, 32'h0);
        chk("tie1_pend_addr", s_haddr, 32'h200);
        chk("tie1_m0_hready", {31'd0, m0_hready}, 32'h1);
        tick();
        chk("tie1_m1_done", {31'd0, m1_hready}, 32'h1);
        chk("tie1_idle", {30'd0, s_htrans}, 32'h0);
        tick();
        drv0(2'b10, 32'h300, 1'b0); #1;
        tick();
        // last grant is M0, so this tie goes to M1
        drv0(2'b10, 32'h310, 1'b0); drv1(2'b10, 32'h320, 1'b0); #1;
        chk("tie2_addr", s_haddr, 32'h320);
        tick();
        drv0(2'b00, 32'h0, 1'b0); drv1(2'b00, 32'h0, 1'b0); #1;
        chk("tie2_m0_stall", {31'd0, m0_hready}, 32'h0);
        chk("tie2_pend_addr", s_haddr, 32'h310);
        tick();
        chk("tie2_m0_done", {31'd0, m0_hready}, 32'h1);
        tick();

        // M0 alone: read then write, zero added latency
        drv0(2'b10, 32'h100, 1'b0); #1;
        chk("m0_rd_addr", s_haddr, 32'h100);
        chk("m0_rd_hwrite", {31'd0, s_hwrite}, 32'h0);
        tick();
        drv0(2'b10, 32'h104, 1'b1); #1;
        chk("m0_wr_addr", s_haddr, 32'h104);
        chk("m0_wr_hwrite", {31'd0, s_hwrite}, 32'h1);
        chk("m0_wr_hsize", {29'd0, s_hsize}, 32'h2);
        chk("m0_wr_hready", {31'd0, m0_hready}, 32'h1);
        tick();
        drv0(2'b00, 32'h0, 1'b0); m0_hwdata = 32'h1234_5678; #1;
        chk("m0_wr_data", s_hwdata, 32'h1234_5678);
        chk("m0_wr_hready2", {31'd0, m0_hready}, 32'h1);
        tick();

        // M1 alone (last grant -> M1), then M1 write captured behind M0
        drv1(2'b10, 32'h208, 1'b0); #1;
        chk("m1_rd_addr", s_haddr, 32'h208);
        tick();
        drv0(2'b10, 32'h400, 1'b0); drv1(2'b10, 32'h500, 1'b1); #1;
        chk("cap_m0_addr", s_haddr, 32'h400);
        tick();
        drv0(2'b00, 32'h0, 1'b0); drv1(2'b00, 32'h0, 1'b0); m1_hwdata = 32'hCAFE_F00D; #1;
        chk("cap_m1_addr", s_haddr, 32'h500);
        chk("cap_m1_hwrite", {31'd0, s_hwrite}, 32'h1);
        chk("cap_m1_stall", {31'd0, m1_hready}, 32'h0);
        tick();
        chk("cap_m1_wdata", s_hwdata, 32'hCAFE_F00D);
        chk("cap_m1_ready", {31'd0, m1_hready}, 32'h1);
        tick();

        // Slave wait states during an M0 data phase while M1 requests
        drv0(2'b10, 32'h600, 1'b0); #1;
        tick();
        drv0(2'b00, 32'h0, 1'b0); drv1(2'b10, 32'h700, 1'b0); s_hready = 1'b0; #1;
        chk("ws1_htrans", {30'd0, s_htrans}, 32'h0);
        chk("ws1_haddr", s_haddr, 32'h0);
        chk("ws1_m0_stall", {31'd0, m0_hready}, 32'h0);
        tick();
        drv1(2'b00, 32'h0, 1'b0); #1;
        chk("ws2_both", {30'd0, m1_hready, m0_hready}, 32'h0);
        chk("ws2_htrans", {30'd0, s_htrans}, 32'h0);
        tick();
        chk("ws3_both", {30'd0, m1_hready, m0_hready}, 32'h0);
        tick();
        s_hready = 1'b1; #1;
        chk("ws_issue_htrans", {30'd0, s_htrans}, 32'h2);
        chk("ws_issue_addr", s_haddr, 32'h700);
        chk("ws_m0_release", {31'd0, m0_hready}, 32'h1);
        chk("ws_m1_stall", {31'd0, m1_hready}, 32'h0);
        tick();
        chk("ws_m1_done", {31'd0, m1_hready}, 32'h1);
        tick();

        // SEQ converted to NONSEQ; error response routed to owner only
        drv0(2'b11, 32'h108, 1'b0); #1;
        chk("seq_htrans", {30'd0, s_htrans}, 32'h2);
        chk("seq_addr", s_haddr, 32'h108);
        tick();
        drv0(2'b00, 32'h0, 1'b0); drv1(2'b10, 32'h800, 1'b0); #1;
        tick();
        drv1(2'b00, 32'h0, 1'b0); s_hresp = 1'b1; s_hrdata = 32'hA5A5_0001; #1;
        chk("err_m1_hresp", {31'd0, m1_hresp}, 32'h1);
        chk("err_m0_hresp", {31'd0, m0_hresp}, 32'h0);
        chk("rdata_bcast", m_hrdata, 32'hA5A5_0001);
        tick();
        chk("err_no_dphase", {30'd0, m1_hresp, m0_hresp}, 32'h0);
        s_hresp = 1'b0;
        tick();

        // Reset while M1 has a pending entry (last grant is M1 -> M0 wins)
        drv0(2'b10, 32'h900, 1'b0); drv1(2'b10, 32'h904, 1'b0); #1;
        chk("rst_tie_addr", s_haddr, 32'h900);
        tick();
        drv0(2'b00, 32'h0, 1'b0); drv1(2'b00, 32'h0, 1'b0);
        chk("rst_pend_set", {31'd0, m1_hready}, 32'h0);
        power_on_reset_n = 1'b0; #1;
        chk("rst_async_m1", {31'd0, m1_hready}, 32'h1);
        chk("rst_async_htrans", {30'd0, s_htrans}, 32'h0);
        tick();
        power_on_reset_n = 1'b1;
        tick();
        chk("post_rst_htrans", {30'd0, s_htrans}, 32'h0);
        chk("post_rst_hready", {30'd0, m1_hready, m0_hready}, 32'h3);
        tick();
        chk("post_rst_no_stale", {30'd0, s_htrans}, 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
